// File: rtl/path_ram_arbiter.sv
// Path-bitmap RAM owner: arbitrates renderer reads, two tile writers and a hardware clear sweep.
// Latency: RAM command in the request cycle; read data and rd_valid one cycle later.
// Backpressure: the renderer is never stalled; the clear sweep yields to reads; writers hold until acked.
module path_ram_arbiter #(
  parameter int DEPTH  = 10000,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data,
  output logic              rd_valid,
  input  logic              wr_req0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic              wr_data0,
  output logic              wr_ack0,
  input  logic              wr_req1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic              wr_data1,
  output logic              wr_ack1,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done,
  output logic              oob_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  input  logic              ram_rdata
);

  // One extra bit so DEPTH may equal 2^ADDR_W without overflowing the bound.
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(DEPTH - 1);

  typedef enum logic {SERVE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic              rr_last;   // index of the writer that won the most recent tie
  logic              rd_hit;    // previous read was in range, so ram_rdata is meaningful

  logic              rd_in_range;
  logic              wr0_in_range;
  logic              wr1_in_range;
  logic              grant0;
  logic              grant1;
  logic              clr_wr;
  logic              grant_oob;

  assign rd_in_range  = ({1'b0, rd_addr}  < DEPTH_W);
  assign wr0_in_range = ({1'b0, wr_addr0} < DEPTH_W);
  assign wr1_in_range = ({1'b0, wr_addr1} < DEPTH_W);
  assign grant_oob    = (grant0 && !wr0_in_range) || (grant1 && !wr1_in_range);

  // Out-of-range reads return 0 rather than whatever the RAM last produced.
  assign rd_data = rd_hit & ram_rdata;

  // Per-cycle arbitration: renderer, then clear sweep, then round-robin writers.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = 1'b0;
    wr_ack0   = 1'b0;
    wr_ack1   = 1'b0;
    grant0    = 1'b0;
    grant1    = 1'b0;
    clr_wr    = 1'b0;
    if (!reset) begin
      if (rd_req) begin
        if (rd_in_range) begin
          ram_en   = 1'b1;
          ram_addr = rd_addr;
        end
      end else if (state == CLEAR) begin
        clr_wr   = 1'b1;
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = clr_addr;
      end else if (wr_req0 && (!wr_req1 || rr_last)) begin
        grant0  = 1'b1;
        wr_ack0 = 1'b1;
        if (wr0_in_range) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = wr_addr0;
          ram_wdata = wr_data0;
        end
      end else if (wr_req1) begin
        grant1  = 1'b1;
        wr_ack1 = 1'b1;
        if (wr1_in_range) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = wr_addr1;
          ram_wdata = wr_data1;
        end
      end
    end
  end

  // Sweep FSM plus the registered status flags and the read-return pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SERVE;
      clr_addr   <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      rr_last    <= 1'b1;
      oob_err    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_hit     <= 1'b0;
    end else begin
      rd_valid   <= rd_req;
      rd_hit     <= rd_req && rd_in_range;
      clear_done <= 1'b0;
      if (grant_oob) begin
        oob_err <= 1'b1;
      end
      // Only a genuine tie moves the round-robin pointer.
      if (wr_req0 && wr_req1 && (grant0 || grant1)) begin
        rr_last <= grant1;
      end
      case (state)
        SERVE: begin
          if (clear_start) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_wr) begin
            if (clr_addr == LAST_CLR) begin
              state      <= SERVE;
              busy       <= 1'b0;
              clear_done <= 1'b1;
              clr_addr   <= '0;
            end else begin
              clr_addr <= clr_addr + ADDR_W'(1);
            end
          end
        end
        default: begin
          state <= SERVE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_path_ram_arbiter.sv
// Bench for path_ram_arbiter: behavioural 1-cycle RAM, vector table for the
// single-cycle arbitration rules, directed sequences for sweep, priority and reset.
module tb_path_ram_arbiter;

  localparam int DEPTH = 10000;

  logic        clk;
  logic        reset;
  logic        rd_req;
  logic [13:0] rd_addr;
  logic        rd_data;
  logic        rd_valid;
  logic        wr_req0;
  logic [13:0] wr_addr0;
  logic        wr_data0;
  logic        wr_ack0;
  logic        wr_req1;
  logic [13:0] wr_addr1;
  logic        wr_data1;
  logic        wr_ack1;
  logic        clear_start;
  logic        busy;
  logic        clear_done;
  logic        oob_err;
  logic        ram_en;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic        ram_wdata;
  bit          ram_rdata;

  int checks;
  int failures;

  bit mem [0:DEPTH-1];
  bit fill_ones;

  path_ram_arbiter #(.DEPTH(DEPTH), .ADDR_W(14)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req0(wr_req0), .wr_addr0(wr_addr0), .wr_data0(wr_data0), .wr_ack0(wr_ack0),
    .wr_req1(wr_req1), .wr_addr1(wr_addr1), .wr_data1(wr_data1), .wr_ack1(wr_ack1),
    .clear_start(clear_start), .busy(busy), .clear_done(clear_done), .oob_err(oob_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (fill_ones) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chka(input string nm, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rq;   logic [13:0] ra;
    logic        w0;   logic [13:0] a0;  logic d0;
    logic        w1;   logic [13:0] a1;  logic d1;
    logic        en;   logic        we;  logic [13:0] addr; logic wd;
    logic        k0;   logic        k1;
    logic        rv;   logic        rdat; logic oob;
  } vec_t;

  function automatic vec_t mk(input int rq, input int ra, input int w0, input int a0, input int d0,
                              input int w1, input int a1, input int d1,
                              input int en, input int we, input int addr, input int wd,
                              input int k0, input int k1, input int rv, input int rdat, input int oob);
    vec_t v;
    v.rq = 1'(rq);   v.ra = 14'(ra);
    v.w0 = 1'(w0);   v.a0 = 14'(a0);  v.d0 = 1'(d0);
    v.w1 = 1'(w1);   v.a1 = 14'(a1);  v.d1 = 1'(d1);
    v.en = 1'(en);   v.we = 1'(we);   v.addr = 14'(addr); v.wd = 1'(wd);
    v.k0 = 1'(k0);   v.k1 = 1'(k1);
    v.rv = 1'(rv);   v.rdat = 1'(rdat); v.oob = 1'(oob);
    return v;
  endfunction

  task automatic wr0(input logic [13:0] a, input logic d);
    @(negedge clk);
    wr_req0 = 1'b1; wr_addr0 = a; wr_data0 = d;
    #1 chk1($sformatf("wr0_ack_%0d", a), wr_ack0, 1'b1);
    @(posedge clk); #1;
    wr_req0 = 1'b0;
  endtask

  task automatic rdchk(input string nm, input logic [13:0] a, input logic exp);
    @(negedge clk);
    rd_req = 1'b1; rd_addr = a;
    @(posedge clk); #1;
    rd_req = 1'b0;
    chk1({nm, "_valid"}, rd_valid, 1'b1);
    chk1({nm, "_data"}, rd_data, exp);
  endtask

  // Runs one full sweep; inj>0 injects three reads of tile 9000 starting at sample inj.
  task automatic run_clear(input int inj, output int done_s, output int busy_c,
                           output int done_c, output int seq_bad, output int wr_c);
    int exp_clr;
    bit did_rd;
    done_s = 0; busy_c = 0; done_c = 0; seq_bad = 0; wr_c = 0; exp_clr = 0;
    @(negedge clk);
    clear_start = 1'b1;
    #1 chk1("clr_busy_before", busy, 1'b0);
    @(posedge clk); #1;
    clear_start = 1'b0;
    if (busy) busy_c++;
    for (int s = 2; s <= 10120; s++) begin
      @(negedge clk);
      did_rd  = (inj > 0) && (s >= inj) && (s < inj + 3);
      rd_req  = did_rd;
      rd_addr = 14'd9000;
      #1;
      if (did_rd) begin
        chk1("clr_stall_we", ram_we, 1'b0);
        chka("clr_stall_addr", ram_addr, 14'd9000);
      end else if (busy) begin
        if (ram_en && ram_we && !ram_wdata) begin
          wr_c++;
          if (ram_addr != exp_clr[13:0]) seq_bad++;
          exp_clr++;
        end else begin
          seq_bad++;
        end
      end
      @(posedge clk); #1;
      if (busy) busy_c++;
      if (clear_done) begin
        done_c++;
        if (done_s == 0) done_s = s;
      end
      if (did_rd) begin
        chk1("clr_stall_rd_valid", rd_valid, 1'b1);
        chk1("clr_stall_rd_data", rd_data, 1'b1);
      end
    end
    rd_req = 1'b0;
  endtask

  vec_t vecs [13];

  initial begin
    int done_s, busy_c, done_c, seq_bad, wr_c, ones, bad;
    logic [0:4] exp_rd;
    logic [13:0] ra [5];

    checks = 0; failures = 0; fill_ones = 1'b0;
    reset = 1'b1; rd_req = 1'b0; rd_addr = '0; clear_start = 1'b0;
    wr_req0 = 1'b1; wr_addr0 = 14'd5; wr_data0 = 1'b1;
    wr_req1 = 1'b0; wr_addr1 = '0;    wr_data1 = 1'b0;

    //       rq ra     w0 a0   d0 w1 a1     d1 en we addr wd k0 k1 rv rd oob
    vecs[0]  = mk(0, 0,    0, 0,   0, 0, 0,     0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0,    1, 4321,1, 0, 0,     0, 1, 1, 4321, 1, 1, 0, 0, 0, 0);
    vecs[2]  = mk(1, 4321, 0, 0,   0, 0, 0,     0, 1, 0, 4321, 0, 0, 0, 1, 1, 0);
    vecs[3]  = mk(1, 10000,0, 0,   0, 0, 0,     0, 0, 0, 0,    0, 0, 0, 1, 0, 0);
    vecs[4]  = mk(0, 0,    1, 10,  1, 1, 20,    1, 1, 1, 10,   1, 1, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0,    1, 10,  1, 1, 20,    1, 1, 1, 20,   1, 0, 1, 0, 0, 0);
    vecs[6]  = mk(0, 0,    1, 10,  1, 1, 20,    1, 1, 1, 10,   1, 1, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0,    1, 10,  1, 1, 20,    1, 1, 1, 20,   1, 0, 1, 0, 0, 0);
    vecs[8]  = mk(1, 10,   1, 10,  1, 1, 20,    1, 1, 0, 10,   0, 0, 0, 1, 1, 0);
    vecs[9]  = mk(1, 20,   0, 0,   0, 0, 0,     0, 1, 0, 20,   0, 0, 0, 1, 1, 0);
    vecs[10] = mk(1, 4322, 0, 0,   0, 0, 0,     0, 1, 0, 4322, 0, 0, 0, 1, 0, 0);
    vecs[11] = mk(0, 0,    0, 0,   0, 1, 12000, 1, 0, 0, 0,    0, 0, 1, 0, 0, 1);
    vecs[12] = mk(0, 0,    1, 4322,0, 0, 0,     0, 1, 1, 4322, 0, 1, 0, 0, 0, 1);

    // Reset state, with a writer already requesting.
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_rd_valid", rd_valid, 1'b0);
    chk1("rst_rd_data", rd_data, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_clear_done", clear_done, 1'b0);
    chk1("rst_oob", oob_err, 1'b0);
    chk1("rst_ram_en", ram_en, 1'b0);
    chk1("rst_ack0", wr_ack0, 1'b0);
    @(negedge clk);
    reset = 1'b0; wr_req0 = 1'b0;

    // Vector table: combinational outputs before the edge, registered ones after.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rd_req = vecs[i].rq;  rd_addr = vecs[i].ra;
      wr_req0 = vecs[i].w0; wr_addr0 = vecs[i].a0; wr_data0 = vecs[i].d0;
      wr_req1 = vecs[i].w1; wr_addr1 = vecs[i].a1; wr_data1 = vecs[i].d1;
      #1;
      chk1($sformatf("v%0d_ram_en", i), ram_en, vecs[i].en);
      chk1($sformatf("v%0d_ram_we", i), ram_we, vecs[i].we);
      chka($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].addr);
      chk1($sformatf("v%0d_ram_wdata", i), ram_wdata, vecs[i].wd);
      chk1($sformatf("v%0d_ack0", i), wr_ack0, vecs[i].k0);
      chk1($sformatf("v%0d_ack1", i), wr_ack1, vecs[i].k1);
      @(posedge clk); #1;
      chk1($sformatf("v%0d_rd_valid", i), rd_valid, vecs[i].rv);
      chk1($sformatf("v%0d_rd_data", i), rd_data, vecs[i].rdat);
      chk1($sformatf("v%0d_oob", i), oob_err, vecs[i].oob);
    end
    rd_req = 1'b0; wr_req0 = 1'b0; wr_req1 = 1'b0;

    // Renderer priority over a held writer.
    ra[0] = 14'd10; ra[1] = 14'd20; ra[2] = 14'd11; ra[3] = 14'd4321; ra[4] = 14'd30;
    exp_rd = 5'b11010;
    @(negedge clk);
    wr_req0 = 1'b1; wr_addr0 = 14'd30; wr_data0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      rd_req = 1'b1; rd_addr = ra[i];
      #1;
      chk1($sformatf("prio_ack0_%0d", i), wr_ack0, 1'b0);
      chk1($sformatf("prio_we_%0d", i), ram_we, 1'b0);
      @(posedge clk); #1;
      chk1($sformatf("prio_rv_%0d", i), rd_valid, 1'b1);
      chk1($sformatf("prio_rd_%0d", i), rd_data, exp_rd[i]);
    end
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    chk1("prio_ack0_release", wr_ack0, 1'b1);
    chka("prio_wr_addr", ram_addr, 14'd30);
    @(posedge clk); #1;
    chk1("prio_rv_idle", rd_valid, 1'b0);
    wr_req0 = 1'b0;
    rdchk("prio_readback", 14'd30, 1'b1);

    // Sticky out-of-range flag.
    repeat (100) @(posedge clk);
    #1 chk1("oob_sticky", oob_err, 1'b1);

    // Plain sweep.
    wr0(14'd0, 1'b1);
    wr0(14'd5000, 1'b1);
    wr0(14'd9999, 1'b1);
    rdchk("pre_clr_9999", 14'd9999, 1'b1);
    run_clear(0, done_s, busy_c, done_c, seq_bad, wr_c);
    chki("clr1_busy_cycles", busy_c, 10000);
    chki("clr1_done_pulses", done_c, 1);
    chki("clr1_done_sample", done_s, 10001);
    chki("clr1_seq_bad", seq_bad, 0);
    chki("clr1_writes", wr_c, 10000);
    rdchk("post_clr_0", 14'd0, 1'b0);
    rdchk("post_clr_5000", 14'd5000, 1'b0);
    rdchk("post_clr_9999", 14'd9999, 1'b0);

    // Sweep stalled by three renderer reads, over a bitmap of all ones.
    @(negedge clk);
    fill_ones = 1'b1;
    @(posedge clk); #1;
    fill_ones = 1'b0;
    run_clear(101, done_s, busy_c, done_c, seq_bad, wr_c);
    chki("clr2_busy_cycles", busy_c, 10003);
    chki("clr2_done_pulses", done_c, 1);
    chki("clr2_done_sample", done_s, 10004);
    chki("clr2_seq_bad", seq_bad, 0);
    chki("clr2_writes", wr_c, 10000);
    ones = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i]) ones++;
    chki("clr2_ones_left", ones, 0);

    // Asynchronous reset in the middle of a sweep.
    @(negedge clk);
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    wr_req0 = 1'b1; wr_addr0 = 14'd40; wr_data0 = 1'b1;
    wr_req1 = 1'b1; wr_addr1 = 14'd41; wr_data1 = 1'b1;
    #1;
    chk1("arst_pre_busy", busy, 1'b1);
    chk1("arst_pre_ack0", wr_ack0, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_ram_en", ram_en, 1'b0);
    chk1("arst_ack0", wr_ack0, 1'b0);
    chk1("arst_ack1", wr_ack1, 1'b0);
    chk1("arst_oob", oob_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk1("arst_tie_ack0", wr_ack0, 1'b1);
    chk1("arst_tie_ack1", wr_ack1, 1'b0);
    chka("arst_tie_addr", ram_addr, 14'd40);
    @(posedge clk); #1;
    chk1("arst_post_busy", busy, 1'b0);
    @(negedge clk);
    #1 chk1("arst_tie2_ack1", wr_ack1, 1'b1);
    @(posedge clk); #1;
    wr_req0 = 1'b0; wr_req1 = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy || clear_done) bad++;
    end
    chki("arst_no_done", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
